dual_alu4_io: RTL and testbench
===============================

Name: dual_alu4_io

Overview:
- Two independent 4-bit ALU lanes, placed in the user project area of the chip harness.
- Operands and opcodes come from the upper user IO pads; results and flags are driven on the lower user IO pads.
- Outputs are registered on the user clock.
- The chip-level bench checks a packed 15-bit result word on pads {io[17:4], io[0]}.

Parameters:
- LANE_W, 4, operand/result width per lane (fixed at 4 for the pad map below)

Ports:
- wb_clk_i  in  1  user clock
- wb_rst_ni  in  1  asynchronous active-low reset
- io_in  in  38  pad inputs
  - [21:18] A0, [25:22] B0, [29:26] A1, [33:30] B1
  - [35:34] SEL1 (lane0 op), [37:36] SEL2 (lane1 op)
- io_out  out  38  pad outputs
  - [0] = out[0], [17:4] = out[14:1]
  - [3] = 0, [2:1] = 0, [37:18] = 0
- io_oeb  out  38  pad output-enable, active low
  - 0 on bits 0 and 17:4
  - 1 on all other bits, including io[3], which the harness drives high

Behaviour:
- Lane opcodes (A,B unsigned 4-bit; R = 4-bit result):
  - 00: R=A+B; C=carry-out; V=signed overflow
  - 01: R=A-B; C=1 when A>=B (no borrow); V=signed overflow of the subtraction
  - 10: R=A&B; C=0; V=0
  - 11: R=A|B; C=0; V=0
- Z=1 when R==0, for every opcode.
- Packed word out[14:0]:
  - [0] C0, [1] Z0, [2] V0, [6:3] R0
  - [7] C1, [11:8] R1, [12] Z1, [13] V1
  - [14] C0&C1
- Timing: io inputs sampled on the rising edge of wb_clk_i; out updates on the same edge; latency 1 cycle from a stable input to pad output.
- Reset: while wb_rst_ni=0, out=15'b0 immediately (async), io_oeb held at its constant value. First valid result is 1 cycle after reset release.
- Inputs changing every cycle: each result corresponds to the inputs sampled on that edge. No handshake, no hold-off.
- Lanes are fully independent. No state other than the output register.

Optional Feature:
- Macro: ALU_IN_SYNC_EN
- Defined:
  - io_in[37:18] pass through a 2-flop synchronizer (both flops reset to 0 by wb_rst_ni) before the ALU.
  - Total latency 3 cycles.
- Undefined: no synchronizer; latency 1 cycle.
- Packing, opcodes and reset values are identical in both builds.

Decomposition:
- Package dual_alu4_pkg holds:
  - opcode constants OP_ADD=2'b00, OP_SUB=2'b01, OP_AND=2'b10, OP_OR=2'b11
  - pad index constants for each A/B/SEL field and each out bit position
- Sub-module alu4_lane: combinational; inputs a[3:0], b[3:0], sel[1:0]; outputs r[3:0], c, z, v. Instantiated twice.
- The top level does pad unpacking, packing, the output register and the optional synchronizer.

Test Plan:
- A0=9,B0=9,A1=0,B1=0,SEL1=SEL2=00 -> out=15'b001000000010101 (R0=2,C0=1,V0=1,Z0=0,Z1=1).
- SEL1=01, A0=5,B0=3; SEL2=01, A1=3,B1=5 -> R0=2,C0=1,V0=0,Z0=0; R1=14,C1=0,V1=0; out[14]=0.
- SEL1=10, A0=12,B0=10; SEL2=11, A1=12,B1=10 -> R0=8,C0=0,V0=0; R1=14,C1=0.
- SEL1=SEL2=00, A0=B0=A1=B1=8 -> R0=R1=0, C=1, Z=1, V=1 on both lanes, out[14]=1.
- Reset sequencing:
  - Drive nonzero inputs, assert wb_rst_ni=0 mid-operation -> out=0 immediately.
  - Release -> out valid after 1 cycle (3 with ALU_IN_SYNC_EN).
- io_oeb check -> 0 on bits 0,17:4 and 1 elsewhere, at all times including during reset.

Source files
------------

// File: rtl/dual_alu4_pkg.sv
// Shared constants for the dual 4-bit ALU pad block: opcodes, pad field
// positions and packed result-word bit positions.
package dual_alu4_pkg;

    localparam int LANE_W   = 4;
    localparam int IO_W     = 38;
    localparam int OUT_W    = 15;

    // Operand/opcode pads occupy io_in[37:18]; PAD_BASE rebases them to bit 0.
    localparam int PAD_BASE = 18;
    localparam int ALU_IN_W = IO_W - PAD_BASE;

    localparam int PAD_A0_LSB   = 18;
    localparam int PAD_B0_LSB   = 22;
    localparam int PAD_A1_LSB   = 26;
    localparam int PAD_B1_LSB   = 30;
    localparam int PAD_SEL1_LSB = 34;
    localparam int PAD_SEL2_LSB = 36;

    localparam int OUT_C0     = 0;
    localparam int OUT_Z0     = 1;
    localparam int OUT_V0     = 2;
    localparam int OUT_R0_LSB = 3;
    localparam int OUT_C1     = 7;
    localparam int OUT_R1_LSB = 8;
    localparam int OUT_Z1     = 12;
    localparam int OUT_V1     = 13;
    localparam int OUT_CC     = 14;

    // Driven pads are io[0] and io[17:4]; every other pad stays an input.
    localparam logic [IO_W-1:0] IO_OEB_CONST = 38'h3F_FFFC_000E;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_OR  = 2'b11
    } alu_op_e;

endpackage

// File: rtl/alu4_lane.sv
// One combinational 4-bit ALU lane: add, subtract, and, or with C/Z/V flags.
module alu4_lane
    import dual_alu4_pkg::*;
(
    input  logic [LANE_W-1:0] a_i,
    input  logic [LANE_W-1:0] b_i,
    input  logic [1:0]        sel_i,
    output logic [LANE_W-1:0] r_o,
    output logic              c_o,
    output logic              z_o,
    output logic              v_o
);

    logic [LANE_W:0] sum_s;
    logic [LANE_W:0] diff_s;

    assign sum_s  = {1'b0, a_i} + {1'b0, b_i};
    assign diff_s = {1'b0, a_i} - {1'b0, b_i};

    // Opcode decode; for subtraction C means "no borrow" (A >= B).
    always_comb begin
        r_o = {LANE_W{1'b0}};
        c_o = 1'b0;
        v_o = 1'b0;
        case (alu_op_e'(sel_i))
            OP_ADD: begin
                r_o = sum_s[LANE_W-1:0];
                c_o = sum_s[LANE_W];
                v_o = (a_i[LANE_W-1] == b_i[LANE_W-1]) && (sum_s[LANE_W-1] != a_i[LANE_W-1]);
            end
            OP_SUB: begin
                r_o = diff_s[LANE_W-1:0];
                c_o = ~diff_s[LANE_W];
                v_o = (a_i[LANE_W-1] != b_i[LANE_W-1]) && (diff_s[LANE_W-1] != a_i[LANE_W-1]);
            end
            OP_AND:  r_o = a_i & b_i;
            OP_OR:   r_o = a_i | b_i;
            default: r_o = {LANE_W{1'b0}};
        endcase
        z_o = (r_o == {LANE_W{1'b0}});
    end

endmodule

// File: rtl/dual_alu4_io.sv
// Two independent ALU lanes between user IO pads, with a registered packed result.
// Define ALU_IN_SYNC_EN to add a 2-flop input synchronizer (latency 3 instead of 1).
module dual_alu4_io
    import dual_alu4_pkg::*;
(
    input  logic            wb_clk_i,
    input  logic            wb_rst_ni,
    input  logic [IO_W-1:0] io_in,
    output logic [IO_W-1:0] io_out,
    output logic [IO_W-1:0] io_oeb
);

    logic [ALU_IN_W-1:0] alu_in_s;
    logic                unused_pads_s;

    assign unused_pads_s = ^io_in[PAD_BASE-1:0];

`ifdef ALU_IN_SYNC_EN
    logic [ALU_IN_W-1:0] sync1_q;
    logic [ALU_IN_W-1:0] sync2_q;

    // Two-stage synchronizer on the operand/opcode pads.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            sync1_q <= {ALU_IN_W{1'b0}};
            sync2_q <= {ALU_IN_W{1'b0}};
        end else begin
            sync1_q <= io_in[IO_W-1:PAD_BASE];
            sync2_q <= sync1_q;
        end
    end

    assign alu_in_s = sync2_q;
`else
    assign alu_in_s = io_in[IO_W-1:PAD_BASE];
`endif

    logic [LANE_W-1:0] r0_s, r1_s;
    logic              c0_s, z0_s, v0_s;
    logic              c1_s, z1_s, v1_s;

    alu4_lane u_lane0 (
        .a_i   (alu_in_s[PAD_A0_LSB-PAD_BASE +: LANE_W]),
        .b_i   (alu_in_s[PAD_B0_LSB-PAD_BASE +: LANE_W]),
        .sel_i (alu_in_s[PAD_SEL1_LSB-PAD_BASE +: 2]),
        .r_o   (r0_s),
        .c_o   (c0_s),
        .z_o   (z0_s),
        .v_o   (v0_s)
    );

    alu4_lane u_lane1 (
        .a_i   (alu_in_s[PAD_A1_LSB-PAD_BASE +: LANE_W]),
        .b_i   (alu_in_s[PAD_B1_LSB-PAD_BASE +: LANE_W]),
        .sel_i (alu_in_s[PAD_SEL2_LSB-PAD_BASE +: 2]),
        .r_o   (r1_s),
        .c_o   (c1_s),
        .z_o   (z1_s),
        .v_o   (v1_s)
    );

    logic [OUT_W-1:0] out_d;
    logic [OUT_W-1:0] out_q;

    // Pack both lanes into the 15-bit result word checked at chip level.
    always_comb begin
        out_d                             = {OUT_W{1'b0}};
        out_d[OUT_C0]                     = c0_s;
        out_d[OUT_Z0]                     = z0_s;
        out_d[OUT_V0]                     = v0_s;
        out_d[OUT_R0_LSB +: LANE_W]       = r0_s;
        out_d[OUT_C1]                     = c1_s;
        out_d[OUT_R1_LSB +: LANE_W]       = r1_s;
        out_d[OUT_Z1]                     = z1_s;
        out_d[OUT_V1]                     = v1_s;
        out_d[OUT_CC]                     = c0_s & c1_s;
    end

    // Result register; the only state in the default build.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            out_q <= {OUT_W{1'b0}};
        end else begin
            out_q <= out_d;
        end
    end

    assign io_out = {20'b0, out_q[OUT_W-1:1], 3'b000, out_q[0]};
    assign io_oeb = IO_OEB_CONST;

endmodule

// File: tb/tb_dual_alu4_io.sv
// Self-checking bench for dual_alu4_io: directed vectors, reset sequencing and
// randomized back-to-back traffic against an arithmetic reference model.
module tb_dual_alu4_io;

`ifdef ALU_IN_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic        clk;
    logic        rst_n;
    logic [37:0] io_in;
    logic [37:0] io_out;
    logic [37:0] io_oeb;

    int checks   = 0;
    int failures = 0;

    dual_alu4_io dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .io_in     (io_in),
        .io_out    (io_out),
        .io_oeb    (io_oeb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference lane: plain integer arithmetic on the opcode definitions.
    function automatic void lane_model(input int a, input int b, input int op,
                                       output int r, output int c, output int z, output int v);
        int sa, sb, full;
        sa = (a >= 8) ? a - 16 : a;
        sb = (b >= 8) ? b - 16 : b;
        c = 0; v = 0;
        case (op)
            0: begin full = a + b; r = full % 16; c = (full > 15) ? 1 : 0;
                     v = ((sa + sb) > 7 || (sa + sb) < -8) ? 1 : 0; end
            1: begin full = a - b + 16; r = full % 16; c = (a >= b) ? 1 : 0;
                     v = ((sa - sb) > 7 || (sa - sb) < -8) ? 1 : 0; end
            2: r = a & b;
            default: r = a | b;
        endcase
        z = (r == 0) ? 1 : 0;
    endfunction

    function automatic logic [14:0] model_word(input int a0, input int b0, input int s1,
                                               input int a1, input int b1, input int s2);
        int r0, c0, z0, v0, r1, c1, z1, v1, w;
        lane_model(a0, b0, s1, r0, c0, z0, v0);
        lane_model(a1, b1, s2, r1, c1, z1, v1);
        w = c0 + 2 * z0 + 4 * v0 + 8 * r0 + 128 * c1 + 256 * r1
            + 4096 * z1 + 8192 * v1 + 16384 * (c0 * c1);
        return w[14:0];
    endfunction

    function automatic logic [37:0] pad_map(input logic [14:0] w);
        logic [37:0] p;
        p = 38'b0;
        p[0] = w[0];
        for (int i = 1; i < 15; i++) p[i + 3] = w[i];
        return p;
    endfunction

    function automatic logic [37:0] mk_in(input int a0, input int b0, input int a1,
                                          input int b1, input int s1, input int s2);
        logic [37:0] v;
        v = {$urandom, $urandom};
        v[21:18] = a0[3:0]; v[25:22] = b0[3:0];
        v[29:26] = a1[3:0]; v[33:30] = b1[3:0];
        v[35:34] = s1[1:0]; v[37:36] = s2[1:0];
        return v;
    endfunction

    logic [37:0] oeb_exp;
    initial begin
        for (int i = 0; i < 38; i++) oeb_exp[i] = !(i == 0 || (i >= 4 && i <= 17));
    end

    task automatic check_io(input string tag, input logic [37:0] exp);
        checks++;
        assert (io_out === exp) else begin
            failures++;
            $error("FAIL %s io_out observed=%h expected=%h", tag, io_out, exp);
        end
    endtask

    task automatic check_oeb(input string tag);
        checks++;
        assert (io_oeb === oeb_exp) else begin
            failures++;
            $error("FAIL %s io_oeb observed=%h expected=%h", tag, io_oeb, oeb_exp);
        end
    endtask

    task automatic directed(input string tag, input int a0, input int b0, input int a1,
                            input int b1, input int s1, input int s2, input logic [14:0] exp_w);
        @(negedge clk);
        io_in = mk_in(a0, b0, a1, b1, s1, s2);
        repeat (LAT) @(posedge clk);
        #1;
        check_io(tag, pad_map(exp_w));
    endtask

    logic [14:0] exp_q[$];
    logic [14:0] w;
    int a0, b0, a1, b1, s1, s2;

    initial begin
        rst_n = 1'b0;
        io_in = 38'h0;
        #2;
        check_io("reset_out", 38'h0);
        check_oeb("reset_oeb");
        repeat (2) @(posedge clk);
        #1;
        check_io("reset_held", 38'h0);
        @(negedge clk);
        rst_n = 1'b1;

        directed("add_9_9", 9, 9, 0, 0, 0, 0, 15'b001000000010101);
        directed("add_9_9_model", 9, 9, 0, 0, 0, 0, model_word(9, 9, 0, 0, 0, 0));
        directed("sub_5_3_3_5", 5, 3, 3, 5, 1, 1,
                 {1'b0, 1'b0, 1'b0, 4'd14, 1'b0, 4'd2, 1'b0, 1'b0, 1'b1});
        directed("and_or_12_10", 12, 10, 12, 10, 2, 3,
                 {1'b0, 1'b0, 1'b0, 4'd14, 1'b0, 4'd8, 1'b0, 1'b0, 1'b0});
        directed("add_8_8_both", 8, 8, 8, 8, 0, 0,
                 {1'b1, 1'b1, 1'b1, 4'd0, 1'b1, 4'd0, 1'b1, 1'b1, 1'b1});
        directed("sub_equal_zero", 7, 7, 0, 15, 1, 1, model_word(7, 7, 1, 0, 15, 1));
        directed("sub_min_ovf", 8, 1, 7, 15, 1, 1, model_word(8, 1, 1, 7, 15, 1));
        check_oeb("oeb_run");

        // Mid-cycle reset with nonzero operands: output must clear immediately.
        directed("pre_reset", 15, 1, 6, 3, 0, 0, model_word(15, 1, 0, 6, 3, 0));
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_io("async_reset", 38'h0);
        check_oeb("oeb_in_reset");
        @(negedge clk);
        io_in = mk_in(6, 5, 9, 4, 1, 1);
        rst_n = 1'b1;
        #1;
        check_io("post_release_zero", 38'h0);
        repeat (LAT) @(posedge clk);
        #1;
        check_io("first_after_release", pad_map(model_word(6, 5, 1, 9, 4, 1)));

        // Back-to-back random traffic: new inputs every cycle.
        exp_q.delete();
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            a0 = $urandom_range(0, 15); b0 = $urandom_range(0, 15);
            a1 = $urandom_range(0, 15); b1 = $urandom_range(0, 15);
            s1 = $urandom_range(0, 3);  s2 = $urandom_range(0, 3);
            io_in = mk_in(a0, b0, a1, b1, s1, s2);
            exp_q.push_back(model_word(a0, b0, s1, a1, b1, s2));
            @(posedge clk);
            #1;
            if (exp_q.size() == LAT) begin
                w = exp_q.pop_front();
                check_io("random", pad_map(w));
            end
        end
        check_oeb("oeb_end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
